// File: rtl/mac_tile_nxn_pkg.sv
// Shared constants, FSM state type and the saturating/wrapping adder for the MAC tile.
// Anything that depends on ACC_W is computed at MAX_ACC_W width and narrowed by the caller.
package mac_pkg;

    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int MAX_ACC_W  = 64;

    typedef enum logic {ACC, HOLD} state_t;

    typedef struct packed {
        logic signed [MAX_ACC_W-1:0] val;
        logic                        ovf;
    } sat_res_t;

    // sum holds an exact ACC_W+1-bit sum, sign-extended to MAX_ACC_W+1 bits
    function automatic sat_res_t sat_add(input logic signed [MAX_ACC_W:0] sum,
                                         input int acc_w,
                                         input logic sat);
        logic signed [MAX_ACC_W:0] one;
        logic signed [MAX_ACC_W:0] hi;
        logic signed [MAX_ACC_W:0] lo;
        logic signed [MAX_ACC_W:0] wrapped;
        sat_res_t r;
        one     = 1;
        hi      = (one <<< (acc_w - 1)) - one;
        lo      = -(one <<< (acc_w - 1));
        wrapped = (sum <<< (MAX_ACC_W + 1 - acc_w)) >>> (MAX_ACC_W + 1 - acc_w);
        r.ovf   = (sum > hi) || (sum < lo);
        if (!r.ovf)
            r.val = sum[MAX_ACC_W-1:0];
        else if (sat)
            r.val = sum[MAX_ACC_W] ? lo[MAX_ACC_W-1:0] : hi[MAX_ACC_W-1:0];
        else
            r.val = wrapped[MAX_ACC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/mac_tile_nxn_if.sv
// Beat input and tile output handshakes of the NxN MAC tile.
interface mac_tile_nxn_if
    import mac_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                              in_valid;
    logic                              in_ready;
    logic [N-1:0][DATA_W-1:0]          in_a;
    logic [N-1:0][DATA_W-1:0]          in_b;
    logic                              in_last;
    logic                              sat_en;
    logic                              out_valid;
    logic                              out_ready;
    logic [N-1:0][N-1:0][ACC_W-1:0]    out_acc;
    logic                              out_ovf;
    logic [CNT_W-1:0]                  beat_cnt;

    modport master (
        output in_valid, in_a, in_b, in_last, sat_en, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, beat_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, sat_en, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, beat_cnt
    );
endinterface

// File: rtl/mac_tile_nxn_pe.sv
// One output-stationary cell: acc += a*b with saturate/wrap, synchronous clear on tile handoff.
module mac_pe
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     sat,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     ovf
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [MAX_ACC_W:0]  sum;
    sat_res_t                   res;

    always_comb begin
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        sum  = (MAX_ACC_W+1)'(acc) + (MAX_ACC_W+1)'(prod);
        res  = sat_add(sum, ACC_W, sat);
    end

    // combinational per-beat overflow; the top qualifies it with the beat strobe
    assign ovf = res.ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= ACC_W'(res.val);
    end
endmodule

// File: rtl/mac_tile_nxn.sv
// NxN output-stationary MAC tile with valid/ready beats in, one completed tile out.
// state | meaning
// ACC   | accepting beats, accumulators hold partial sums
// HOLD  | tile complete, waiting for out_ready
module mac_tile_nxn
    import mac_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mac_tile_nxn_if.slave bus
);
    generate
        if (N < 1 || ACC_W < 2*DATA_W || ACC_W > MAX_ACC_W) begin : g_bad_params
            $error("mac_tile_nxn: need N >= 1 and 2*DATA_W <= ACC_W <= MAX_ACC_W");
        end
    endgenerate

    state_t           state;
    logic             sat_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;
    logic [N*N-1:0]   pe_ovf;
    logic             beat;
    logic             handoff;
    logic             sat_cur;

    assign beat    = bus.in_valid & (state == ACC);
    assign handoff = bus.out_ready & (state == HOLD);
    // first beat of a tile uses sat_en directly, later beats the latched copy
    assign sat_cur = (cnt == '0) ? bus.sat_en : sat_q;

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_ovf   = ovf_q;
    assign bus.beat_cnt  = cnt;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (beat),
                .clr   (handoff),
                .sat   (sat_cur),
                .a     (bus.in_a[i]),
                .b     (bus.in_b[j]),
                .acc   (bus.out_acc[i][j]),
                .ovf   (pe_ovf[i*N+j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (beat) begin
                        if (cnt == '0)
                            sat_q <= bus.sat_en;
                        if (cnt != '1)
                            cnt <= cnt + 1'b1;
                        if (|pe_ovf)
                            ovf_q <= 1'b1;
                        if (bus.in_last)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= ACC;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: doc/mac_tile_nxn.md
Name: mac_tile_nxn

Overview:
Parametrised output-stationary NxN MAC tile, the successor to the fixed 4x4 array with a single `en` strobe. Each accepted beat supplies an N-element column vector `a` and an N-element row vector `b`. Every cell (i,j) accumulates `a[i]*b[j]`, so K beats compute one NxN tile of a matrix product. Inputs and outputs use valid/ready handshakes, and the block adds per-tile saturation or wrap mode, a sticky overflow flag and a beat counter, ready to sit behind an AXI-stream front end.

Parameters:
- N, 4, tile dimension (rows = cols = N); N >= 1.
- DATA_W, 8, signed operand width.
- ACC_W, 32, signed accumulator width. Elaboration error unless ACC_W >= 2*DATA_W.
- CNT_W, 16, beat-counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  [N][DATA_W] signed  column vector, element i feeds row i.
- in_b  in  [N][DATA_W] signed  row vector, element j feeds column j.
- in_last  in  1  final beat of the current tile.
- sat_en  in  1  1 = saturate, 0 = two's-complement wrap.
- out_valid  out  1  completed tile available.
- out_ready  in  1  consumer accepts the tile.
- out_acc  out  [N][N][ACC_W] signed  accumulator array.
- out_ovf  out  1  sticky: overflow occurred in any cell this tile.
- beat_cnt  out  CNT_W  beats accepted in the current tile.

Behaviour:
- **Reset (async, rst_n=0):**
  - state=ACC, all acc=0, out_valid=0, out_ovf=0, beat_cnt=0, sat mode register=0.
  - in_ready follows state, so it is 1 after release.
  - Reset mid-tile discards partial sums; no output is produced.
- **FSM states:** ACC and HOLD.
- **ACC:**
  - in_ready=1, out_valid=0.
  - Beat = in_valid & in_ready. On a beat, for every i,j: `acc[i][j] <= f(acc[i][j] + sext(a[i]*b[j]))`.
    - Product is full 2*DATA_W signed, sign-extended to ACC_W+1.
    - The sum is formed in ACC_W+1 bits.
  - Overflow = the sum is outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    - Saturate mode: clamp to the bound.
    - Wrap mode: keep the low ACC_W bits.
    - Either mode sets out_ovf (sticky, OR across all cells and beats).
  - Saturation mode is latched from sat_en on the first beat of a tile (beat_cnt==0) and held for the rest of the tile; mid-tile sat_en changes are ignored.
  - beat_cnt increments on each beat and saturates at 2^CNT_W-1 (no wrap).
  - Beat with in_last=1: accumulate that beat, then ACC->HOLD. out_valid=1 on the next cycle, with final values on out_acc.
  - No beat: all state holds.
- **HOLD:**
  - in_ready=0, out_valid=1.
  - out_acc, out_ovf and beat_cnt are stable; in_* inputs are ignored.
  - On out_valid & out_ready: HOLD->ACC; all acc=0, out_ovf=0, beat_cnt=0, out_valid=0 next cycle.
  - out_ready held low: hold indefinitely (backpressure).
- **Timing:**
  - Throughput: 1 beat/cycle in ACC.
  - Latency from last beat accepted to out_valid: 1 cycle.
  - Minimum 1 bubble cycle between tiles: in_ready is low for at least the cycle the tile is handed off.
- **out_acc visibility:** driven directly from acc registers. During ACC it shows partial sums, which are meaningful only when out_valid=1.
- **Boundary cases:**
  - Single-beat tile (in_last on beat 1) is legal.
  - in_valid asserted during HOLD is not a beat; the source must hold it until in_ready.
  - out_ready asserted in ACC has no effect.

Decomposition:
- Package mac_pkg holds:
  - default parameter constants;
  - state enum typedef {ACC, HOLD};
  - a function `sat_add` (ACC_W+1 sum, mode) returning the result and an overflow bit.
- Sub-module mac_pe holds one cell: the acc register, multiply, sat_add, clear, and an ovf output.
  - It is instantiated N*N times via generate.
- The top level owns the FSM, beat_cnt, the sat-mode latch and the ovf OR-reduction.

Test Plan:
1. **Reset and single-beat tile.** Drive rst_n=0 then 1. Check in_ready=1 and out_acc all 0. Send one beat a=[3,0,0,0], b=[4,0,0,0], last=1, out_ready=1. Required: next cycle out_valid=1, acc[0][0]=12, others 0, beat_cnt=1, ovf=0, then cleared.
2. **Multi-beat signed tile.** 2 beats:
   - beat 1: a=[5,1,0,0], b=[-2,3,0,0];
   - beat 2: a=[1,1,0,0], b=[2,2,0,0], last.
   Required: acc[0][0]=-8, acc[0][1]=17, acc[1][0]=0, acc[1][1]=5, beat_cnt=2.
3. **Saturation.** Set ACC_W=16, sat_en=1. Send 3 beats of a[0]=b[0]=127. Required: acc[0][0]=32767 and ovf=1 (48387 clamped).
   - Repeat with -128*-128 x2: 32768 clamps to 32767, ovf=1.
4. **Wrap.** Same as the -128*-128 x2 case with sat_en=0. Required: acc[0][0]=-32768, ovf=1.
5. **Backpressure.** Hold out_ready=0 for 10 cycles after a tile. Required: out_valid stays 1, out_acc stable, in_ready=0, in_valid beats ignored. Release out_ready. Required: next tile starts from 0.
6. **Async reset mid-tile.** Drop rst_n after 2 of 4 beats. Required: all acc=0, beat_cnt=0, out_valid=0 immediately, with no clock edge needed.
